// File: rtl/stream_rr_arbiter.sv
// Round-robin N:1 stream arbiter; STREAM_ARB_PACKET_LOCK_EN holds the grant until tlast.
// Latency: one cycle from recv handshake to send_* (single output register slot).
// Backpressure: the slot holds while send_tready=0 and all recv_tready drop until it frees.
module stream_rr_arbiter #(
    parameter int N    = 4,
    parameter int BITS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N-1:0]           recv_tvalid,
    output logic [N-1:0]           recv_tready,
    input  logic [N*BITS-1:0]      recv_tdata,
    input  logic [N-1:0]           recv_tlast,
    output logic                   send_tvalid,
    input  logic                   send_tready,
    output logic [BITS-1:0]        send_tdata,
    output logic                   send_tlast,
    output logic [$clog2(N)-1:0]   send_tid
);

    localparam int IW = $clog2(N);

    logic [BITS-1:0] recv_word [N];
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   rr_pick;
    logic [IW-1:0]   rr_cand;
    logic            rr_found;
    logic            grant_vld;
    logic            slot_free;
    logic            accept;
    logic            run_en;
    logic            locked;

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign recv_word[i] = recv_tdata[i*BITS +: BITS];
    end

    // Keeps all readies low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    always_comb begin
        rr_pick  = '0;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = IW'((int'(last_idx) + k) % N);
            if (!rr_found && recv_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_pick  = rr_cand;
            end
        end
    end

`ifdef STREAM_ARB_PACKET_LOCK_EN
    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE) begin
            if (accept && !recv_tlast[grant]) begin
                state_nxt = LOCKED;
            end
        end else begin
            if (accept && recv_tlast[grant]) begin
                state_nxt = IDLE;
            end
        end
    end

    assign locked = (state == LOCKED);
`else
    assign locked = 1'b0;
`endif

    // While locked, last_idx already holds the owner of the packet in flight.
    assign grant     = locked ? last_idx : rr_pick;
    assign grant_vld = locked | rr_found;
    assign slot_free = !send_tvalid || send_tready;
    assign accept    = run_en && slot_free && grant_vld && recv_tvalid[grant];

    always_comb begin
        recv_tready = '0;
        if (run_en && slot_free && grant_vld) begin
            recv_tready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            send_tvalid <= 1'b0;
            send_tdata  <= '0;
            send_tlast  <= 1'b0;
            send_tid    <= '0;
            last_idx    <= IW'(N - 1);
        end else if (slot_free) begin
            send_tvalid <= accept;
            if (accept) begin
                send_tdata <= recv_word[grant];
                send_tlast <= recv_tlast[grant];
                send_tid   <= grant;
                last_idx   <= grant;
            end
        end
    end

endmodule
